// File: rtl/id_operand_fetch_pkg.sv
// id_operand_fetch_pkg: shared widths, zero-register constant and operand-source encoding.
package id_operand_fetch_pkg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;
   typedef enum logic [1:0] {SRC_ZERO, SRC_EX, SRC_MEM, SRC_RF} src_e;
endpackage

// File: rtl/id_operand_fetch_if.sv
// id_operand_fetch_if: decode input, regfile read, bypass buses and ID/EX output of operand fetch.
interface id_operand_fetch_if
   import id_operand_fetch_pkg::*;
   #(parameter int DW = 32, parameter int AW = 5, parameter int CNTW = 32);
   logic          flush;
   logic          in_valid, in_ready, in_use_rs, in_use_rt;
   logic [AW-1:0] in_rs, in_rt, raddr1, raddr2;
   logic [DW-1:0] rdata1, rdata2;
   logic          ex_we, ex_is_load, mem_we;
   logic [AW-1:0] ex_waddr, mem_waddr;
   logic [DW-1:0] ex_result, mem_result;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_op_a, out_op_b;
   logic [CNTW-1:0] stall_cnt;
   src_e          src_a, src_b;
   modport master (output flush, in_valid, in_use_rs, in_use_rt, in_rs, in_rt, rdata1, rdata2,
                   ex_we, ex_is_load, ex_waddr, ex_result, mem_we, mem_waddr, mem_result, out_ready,
                   input in_ready, raddr1, raddr2, out_valid, out_op_a, out_op_b, stall_cnt, src_a, src_b);
   modport slave (input flush, in_valid, in_use_rs, in_use_rt, in_rs, in_rt, rdata1, rdata2,
                  ex_we, ex_is_load, ex_waddr, ex_result, mem_we, mem_waddr, mem_result, out_ready,
                  output in_ready, raddr1, raddr2, out_valid, out_op_a, out_op_b, stall_cnt, src_a, src_b);
endinterface

// File: rtl/id_operand_fetch_operand_bypass_mux.sv
// operand_bypass_mux: resolves one source operand from regfile/EX/MEM and flags a load-use hit.
module operand_bypass_mux
   import id_operand_fetch_pkg::*;
   #(parameter int DW = 32, parameter int AW = 5)
   (
   input  logic [AW-1:0] addr_i,
   input  logic          use_i,
   input  logic [DW-1:0] rdata_i,
   input  logic          ex_we_i,
   input  logic [AW-1:0] ex_waddr_i,
   input  logic          ex_is_load_i,
   input  logic [DW-1:0] ex_result_i,
   input  logic          mem_we_i,
   input  logic [AW-1:0] mem_waddr_i,
   input  logic [DW-1:0] mem_result_i,
   output logic [DW-1:0] data_o,
   output src_e          src_o,
   output logic          hz_o
   );
   logic zero, ex_hit, mem_hit;
   always_comb begin
      zero    = addr_i == AW'(REG_ZERO);
      ex_hit  = ex_we_i && ex_waddr_i == addr_i;
      mem_hit = mem_we_i && mem_waddr_i == addr_i;
      // EX is the younger producer, so it outranks MEM; a load in EX has no data yet
      src_o   = zero ? SRC_ZERO : (ex_hit && !ex_is_load_i) ? SRC_EX : mem_hit ? SRC_MEM : SRC_RF;
      data_o  = src_o == SRC_ZERO ? '0 : src_o == SRC_EX ? ex_result_i :
                src_o == SRC_MEM ? mem_result_i : rdata_i;
      hz_o    = use_i && ex_hit && ex_is_load_i && !zero;
   end
endmodule

// File: rtl/id_operand_fetch.sv
// id_operand_fetch: ID-stage operand read with EX/MEM bypass, load-use bubbling and ID/EX register.
module id_operand_fetch
   import id_operand_fetch_pkg::*;
   #(parameter int DW = 32, parameter int AW = 5, parameter int CNTW = 32)
   (
   input  logic           clk,
   input  logic           rst,
   id_operand_fetch_if.slave bus
   );
   logic [DW-1:0]   data_a, data_b, op_a_q, op_a_d, op_b_q, op_b_d;
   logic            hz_a, hz_b, hz, out_free, ld, out_valid_q, out_valid_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   operand_bypass_mux #(.DW(DW), .AW(AW)) u_mux_a (
      .addr_i(bus.in_rs), .use_i(bus.in_use_rs), .rdata_i(bus.rdata1),
      .ex_we_i(bus.ex_we), .ex_waddr_i(bus.ex_waddr), .ex_is_load_i(bus.ex_is_load),
      .ex_result_i(bus.ex_result), .mem_we_i(bus.mem_we), .mem_waddr_i(bus.mem_waddr),
      .mem_result_i(bus.mem_result), .data_o(data_a), .src_o(bus.src_a), .hz_o(hz_a));
   operand_bypass_mux #(.DW(DW), .AW(AW)) u_mux_b (
      .addr_i(bus.in_rt), .use_i(bus.in_use_rt), .rdata_i(bus.rdata2),
      .ex_we_i(bus.ex_we), .ex_waddr_i(bus.ex_waddr), .ex_is_load_i(bus.ex_is_load),
      .ex_result_i(bus.ex_result), .mem_we_i(bus.mem_we), .mem_waddr_i(bus.mem_waddr),
      .mem_result_i(bus.mem_result), .data_o(data_b), .src_o(bus.src_b), .hz_o(hz_b));
   always_comb begin
      hz          = bus.in_valid && (hz_a || hz_b);
      out_free    = !out_valid_q || bus.out_ready;
      ld          = !bus.flush && out_free && bus.in_valid && !hz;
      out_valid_d = bus.flush ? 1'b0 : out_free ? bus.in_valid && !hz : out_valid_q;
      op_a_d      = ld ? data_a : op_a_q;
      op_b_d      = ld ? data_b : op_b_q;
      stall_cnt_d = (!bus.flush && out_free && hz) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
   assign bus.raddr1    = bus.in_rs;
   assign bus.raddr2    = bus.in_rt;
   assign bus.in_ready  = !bus.flush && out_free && !hz;
   assign bus.out_valid = out_valid_q;
   assign bus.out_op_a  = op_a_q;
   assign bus.out_op_b  = op_b_q;
   assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- ID-stage read side of the 32x32 general register file.
- Drives the file's two combinational read ports, bypasses results from the EX and MEM stages, and detects load-use hazards, stalling for one bubble on each.
- Registers the resolved operands into the ID/EX boundary using a valid/ready handshake.
- Also keeps a free-running count of stall cycles for performance debug.

Parameters:
- DW, 32, data width of operands and register file.
- AW, 5, register address width.
- CNTW, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  kill the held instruction and the output stage (branch/exception redirect).
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  unit accepts the instruction this cycle.
- in_rs  in  AW  source register A address.
- in_rt  in  AW  source register B address.
- in_use_rs  in  1  instruction reads rs.
- in_use_rt  in  1  instruction reads rt.
- raddr1  out  AW  register file read address 1.
- raddr2  out  AW  register file read address 2.
- rdata1  in  DW  register file read data 1, combinational.
- rdata2  in  DW  register file read data 2, combinational.
- ex_we  in  1  EX-stage instruction writes a register.
- ex_waddr  in  AW  EX-stage destination.
- ex_is_load  in  1  EX-stage instruction is a load (result not yet available).
- ex_result  in  DW  EX-stage ALU result.
- mem_we  in  1  MEM-stage instruction writes a register.
- mem_waddr  in  AW  MEM-stage destination.
- mem_result  in  DW  MEM-stage final result, including load data.
- out_valid  out  1  operands valid toward EX.
- out_ready  in  1  EX accepts.
- out_op_a  out  DW  resolved operand A.
- out_op_b  out  DW  resolved operand B.
- stall_cnt  out  CNTW  cycles in which the unit held because of a load-use hazard.

Behaviour:
- Reset (rst=0 at a rising edge): out_valid=0, out_op_a=0, out_op_b=0, stall_cnt=0.
- Read ports: raddr1=in_rs and raddr2=in_rt, combinational, always driven.
- Per-operand resolution, combinational, in priority order:
  1. Address 0 gives 0.
  2. Otherwise, if ex_we && ex_waddr==addr && !ex_is_load, use ex_result.
  3. Otherwise, if mem_we && mem_waddr==addr, use mem_result.
  4. Otherwise use the regfile rdata.
- No write-back bypass is needed: the register file commits on the falling clock edge, so a WB value is already visible on rdata before the next rising edge.
- Load-use hazard (hz) is asserted when all of the following hold:
  - in_valid is high;
  - ex_we && ex_is_load is true;
  - ex_waddr is non-zero;
  - ex_waddr matches in_rs with in_use_rs set, or matches in_rt with in_use_rt set.
- Output stage is a single register:
  - out_free = !out_valid || out_ready.
  - in_ready = out_free && !hz.
- At each rising edge, when out_free is true:
  - out_valid <= in_valid && !hz.
  - out_op_a and out_op_b load the resolved values when in_valid && !hz; otherwise they hold.
- When out_free is false, all output registers hold (back-pressure). Resolved data is not captured in this case; it is re-resolved when the stage frees.
- Hazard lasts one cycle in normal flow: the next cycle the load is in MEM and its value comes through mem_result. If EX is itself stalled, hz persists and the unit keeps bubbling.
- stall_cnt increments by 1 on each edge where hz && out_free. It wraps from all-ones to 0.
- flush has priority over everything except reset: out_valid <= 0 and in_ready=0 that cycle. stall_cnt is not incremented on a flush cycle.
- A simultaneous EX and MEM match on the same register selects EX (younger instruction).
- Reset asserted mid-stall clears the stall; no residual bubble follows release.

Decomposition:
- Shared package holds: DW/AW constants, REG_ZERO=5'd0, and the operand-source encoding (SRC_ZERO, SRC_EX, SRC_MEM, SRC_RF) for debug visibility.
- One sub-module, operand_bypass_mux, instantiated twice (A and B). It resolves one operand from an address, rdata, and the EX/MEM bypass buses, and outputs data plus a per-operand hazard flag.
- The top level ORs the two hazard flags and owns the output register and the counter.

Test Plan:
- Reset, then in_rs=3, in_rt=4, no bypass, rdata1=0x11, rdata2=0x22, out_ready=1 -> next edge out_valid=1, op_a=0x11, op_b=0x22.
- in_rs=0, rdata1=0xDEAD, with ex_we=1, ex_waddr=0, ex_result=5 -> op_a=0, hz=0.
- ex_we=1, ex_waddr=7, ex_result=0xAA, and mem_we=1, mem_waddr=7, mem_result=0xBB, in_rs=7 -> op_a=0xAA (EX wins).
- Load-use: ex_is_load=1, ex_waddr=9, in_rt=9, in_use_rt=1:
  - Cycle 1: in_ready=0, out_valid=0 next edge, stall_cnt=1.
  - Cycle 2: mem_waddr=9, mem_result=0x1234 -> op_b=0x1234, in_ready=1.
- Back-pressure: out_valid=1 with out_ready=0 for 3 cycles -> outputs hold, in_ready=0, stall_cnt unchanged. Release -> next operands load.
- flush during a load-use stall -> out_valid=0 next edge, stall_cnt unchanged. Then rst=0 for one edge -> all outputs and stall_cnt are 0.
